// File: rtl/sec_ded_hsiao_pkg.sv
// Shared constants and elaboration-time helpers for the Hsiao SEC-DED decoder.
//   cw_for_dw  : check width needed to protect a dw-bit data word
//   hsiao_col  : i-th H-matrix data column (odd weight >= 3, ascending order)
//   popcount   : number of set bits in a 32-bit value
package sec_ded_hsiao_pkg;

   localparam int MAX_DW = 57;

   function automatic int popcount(input logic [31:0] v);
      int n;
      n = 0;
      for (int k = 0; k < 32; k++) begin
         n += int'(v[k]);
      end
      return n;
   endfunction

   // Smallest r whose odd-weight (>=3) r-bit values number at least dw.
   function automatic int cw_for_dw(input int dw);
      int cnt;
      for (int r = 3; r <= 8; r++) begin
         cnt = 0;
         for (int v = 0; v < (1 << r); v++) begin
            if (popcount(v) >= 3 && (popcount(v) % 2) == 1) cnt++;
         end
         if (cnt >= dw) return r;
      end
      return 8;
   endfunction

   function automatic int hsiao_col(input int cw, input int i);
      int cnt;
      cnt = 0;
      for (int v = 0; v < (1 << cw); v++) begin
         if (popcount(v) >= 3 && (popcount(v) % 2) == 1) begin
            if (cnt == i) return v;
            cnt++;
         end
      end
      return 0;
   endfunction

endpackage

// File: rtl/sec_ded_hsiao_syndrome.sv
// Combinational Hsiao check-bit generator.
//   i_data  [DW-1:0] : data word
//   o_check [CW-1:0] : check bits; bit j is the XOR of every data bit whose
//                      H-matrix column has bit j set
module sec_ded_hsiao_syndrome
   import sec_ded_hsiao_pkg::*;
#(
   parameter int DW = 11,
   parameter int CW = 5
) (
   input  logic [DW-1:0] i_data,
   output logic [CW-1:0] o_check
);

   // Row j of the data part of H, flattened into a constant selection mask.
   function automatic logic [DW-1:0] row_mask(input int j);
      logic [DW-1:0] m;
      m = '0;
      for (int i = 0; i < DW; i++) begin
         m[i] = ((hsiao_col(CW, i) >> j) & 1) != 0;
      end
      return m;
   endfunction

   for (genvar j = 0; j < CW; j++) begin : g_row
      localparam logic [DW-1:0] ROW_MASK = row_mask(j);
      assign o_check[j] = ^(i_data & ROW_MASK);
   end

endmodule

// File: rtl/sec_ded_hsiao_decode.sv
// Registered Hsiao SEC-DED decoder for the memory read path.
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   in_valid     : data/control valid this cycle
//   data         : received data word (DW bits)
//   control      : received check bits (CW bits, derived from DW)
//   out_valid    : in_valid delayed by one cycle
//   cdata        : corrected data
//   control_new  : corrected / regenerated check bits
//   secr         : single error corrected (data or check bit)
//   dede         : double or uncorrectable error detected
module sec_ded_hsiao_decode
   import sec_ded_hsiao_pkg::*;
#(
   parameter  int DW = 11,
   localparam int CW = cw_for_dw(DW)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] data,
   input  logic [CW-1:0] control,
   output logic          out_valid,
   output logic [DW-1:0] cdata,
   output logic [CW-1:0] control_new,
   output logic          secr,
   output logic          dede
);

   if (DW < 4 || DW > MAX_DW) begin : g_bad_dw
      $error("sec_ded_hsiao_decode: DW out of range 4..57");
   end

   logic [CW-1:0] w_enc_rx;
   logic [CW-1:0] w_enc_fix;
   logic [CW-1:0] w_syn;
   logic [DW-1:0] w_hit;
   logic [DW-1:0] w_cdata;
   logic [CW-1:0] w_control_new;
   int            w_syn_wt;
   logic          w_syn_zero;
   logic          w_fix_data;
   logic          w_fix_check;
   logic          w_secr;
   logic          w_dede;

   logic          r_out_valid;
   logic [DW-1:0] r_cdata;
   logic [CW-1:0] r_control_new;
   logic          r_secr;
   logic          r_dede;

   sec_ded_hsiao_syndrome #(.DW(DW), .CW(CW)) u_enc_rx (
      .i_data  (data),
      .o_check (w_enc_rx)
   );

   assign w_syn = control ^ w_enc_rx;

   // One-hot flip vector: a syndrome matching data column i points at bit i.
   // Even-weight or unused odd-weight syndromes match nothing.
   for (genvar i = 0; i < DW; i++) begin : g_col
      localparam logic [CW-1:0] COL = CW'(hsiao_col(CW, i));
      assign w_hit[i] = (w_syn == COL);
   end

   assign w_cdata = data ^ w_hit;

   sec_ded_hsiao_syndrome #(.DW(DW), .CW(CW)) u_enc_fix (
      .i_data  (w_cdata),
      .o_check (w_enc_fix)
   );

   always_comb begin
      w_syn_wt    = popcount(32'(w_syn));
      w_syn_zero  = (w_syn == '0);
      w_fix_data  = |w_hit;
      w_fix_check = (w_syn_wt == 1);
      w_secr      = w_fix_data | w_fix_check;
      w_dede      = !w_syn_zero && !w_secr;
      // On a check-bit error cdata == data, so the re-encode equals the
      // received control with the faulty bit flipped.
      w_control_new = w_secr ? w_enc_fix : control;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid   <= 1'b0;
         r_cdata       <= '0;
         r_control_new <= '0;
         r_secr        <= 1'b0;
         r_dede        <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_cdata       <= w_cdata;
            r_control_new <= w_control_new;
            r_secr        <= w_secr;
            r_dede        <= w_dede;
         end else begin
            r_secr <= 1'b0;
            r_dede <= 1'b0;
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign cdata       = r_cdata;
   assign control_new = r_control_new;
   assign secr        = r_secr;
   assign dede        = r_dede;

endmodule

// File: tb/tb_sec_ded_hsiao_decode.sv
module tb_sec_ded_hsiao_decode;

   localparam int DW = 11;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [DW-1:0] data;
   logic [CW-1:0] control;
   logic          out_valid;
   logic [DW-1:0] cdata;
   logic [CW-1:0] control_new;
   logic          secr;
   logic          dede;

   int n_checks = 0;
   int n_errors = 0;

   // Hand-listed data columns for CW=5.
   logic [4:0] cols [DW] = '{5'h07, 5'h0B, 5'h0D, 5'h0E, 5'h13, 5'h15,
                              5'h16, 5'h19, 5'h1A, 5'h1C, 5'h1F};

   always #5 clk = ~clk;

   sec_ded_hsiao_decode #(.DW(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .data        (data),
      .control     (control),
      .out_valid   (out_valid),
      .cdata       (cdata),
      .control_new (control_new),
      .secr        (secr),
      .dede        (dede)
   );

   function automatic logic [4:0] enc(input logic [10:0] d);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < DW; i++) if (d[i]) c ^= cols[i];
      return c;
   endfunction

   // Drive one word at the falling edge, return 1 ns after the capturing edge.
   task automatic drive(input logic [10:0] d, input logic [4:0] c, input logic v);
      @(negedge clk);
      data = d; control = c; in_valid = v;
      @(posedge clk);
      #1;
   endtask

   // {out_valid, secr, dede, control_new, cdata}
   function automatic logic [18:0] obs();
      return {out_valid, secr, dede, control_new, cdata};
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; data = '0; control = '0;
      #1;
      n_checks++;
      if (obs() !== 19'h0) begin
         n_errors++;
         $display("FAIL reset_state: got %h expected %h", obs(), 19'h0);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      drive(11'h7FF, 5'h1F, 1'b1);
      n_checks++;
      if (obs() !== {1'b1, 1'b0, 1'b0, 5'h1F, 11'h7FF}) begin
         n_errors++;
         $display("FAIL clean_ones: got %h expected %h", obs(), {1'b1, 1'b0, 1'b0, 5'h1F, 11'h7FF});
      end
      drive(11'h7FF, 5'h1E, 1'b1);
      n_checks++;
      if (obs() !== {1'b1, 1'b1, 1'b0, 5'h1F, 11'h7FF}) begin
         n_errors++;
         $display("FAIL check_bit0_err: got %h expected %h", obs(), {1'b1, 1'b1, 1'b0, 5'h1F, 11'h7FF});
      end
      drive(11'h7EF, 5'h1E, 1'b1);
      n_checks++;
      if (obs() !== {1'b1, 1'b0, 1'b1, 5'h1E, 11'h7EF}) begin
         n_errors++;
         $display("FAIL double_err: got %h expected %h", obs(), {1'b1, 1'b0, 1'b1, 5'h1E, 11'h7EF});
      end
      drive(11'h400, 5'h00, 1'b1);
      n_checks++;
      if (obs() !== {1'b1, 1'b1, 1'b0, 5'h00, 11'h000}) begin
         n_errors++;
         $display("FAIL data_bit10_err: got %h expected %h", obs(), {1'b1, 1'b1, 1'b0, 5'h00, 11'h000});
      end
      drive(11'h000, 5'h00, 1'b1);
      n_checks++;
      if (obs() !== {1'b1, 1'b0, 1'b0, 5'h00, 11'h000}) begin
         n_errors++;
         $display("FAIL clean_zero: got %h expected %h", obs(), {1'b1, 1'b0, 1'b0, 5'h00, 11'h000});
      end
   endtask

   task automatic test_hold();
      drive(11'h7FF, 5'h1E, 1'b1);
      drive(11'h123, 5'h0A, 1'b0);
      n_checks++;
      if (obs() !== {1'b0, 1'b0, 1'b0, 5'h1F, 11'h7FF}) begin
         n_errors++;
         $display("FAIL idle_hold: got %h expected %h", obs(), {1'b0, 1'b0, 1'b0, 5'h1F, 11'h7FF});
      end
   endtask

   task automatic test_single_sweep();
      logic [10:0] d;
      logic [4:0]  c;
      logic [15:0] cw;
      for (int k = 0; k < 3; k++) begin
         d = 11'($urandom_range(0, 2047));
         c = enc(d);
         for (int p = 0; p < 16; p++) begin
            cw = {c, d} ^ (16'h1 << p);
            drive(cw[10:0], cw[15:11], 1'b1);
            n_checks++;
            if (obs() !== {1'b1, 1'b1, 1'b0, c, d}) begin
               n_errors++;
               $display("FAIL single_flip pos=%0d: got %h expected %h", p, obs(), {1'b1, 1'b1, 1'b0, c, d});
            end
         end
      end
   endtask

   task automatic test_double_sweep();
      logic [10:0] d;
      logic [4:0]  c;
      logic [15:0] cw;
      d = 11'($urandom_range(0, 2047));
      c = enc(d);
      for (int a = 0; a < 16; a++) begin
         for (int b = a + 1; b < 16; b++) begin
            cw = {c, d} ^ (16'h1 << a) ^ (16'h1 << b);
            drive(cw[10:0], cw[15:11], 1'b1);
            n_checks++;
            if (obs() !== {1'b1, 1'b0, 1'b1, cw[15:11], cw[10:0]}) begin
               n_errors++;
               $display("FAIL double_flip %0d,%0d: got %h expected %h", a, b, obs(), {1'b1, 1'b0, 1'b1, cw[15:11], cw[10:0]});
            end
         end
      end
   endtask

   task automatic test_reset_midstream();
      drive(11'h400, 5'h00, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (obs() !== 19'h0) begin
         n_errors++;
         $display("FAIL async_reset: got %h expected %h", obs(), 19'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      data = 11'h0F0; control = enc(11'h0F0) ^ 5'h04; in_valid = 1'b1;
      #1;
      n_checks++;
      if (obs() !== 19'h0) begin
         n_errors++;
         $display("FAIL post_reset_idle: got %h expected %h", obs(), 19'h0);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (obs() !== {1'b1, 1'b1, 1'b0, enc(11'h0F0), 11'h0F0}) begin
         n_errors++;
         $display("FAIL first_after_reset: got %h expected %h", obs(), {1'b1, 1'b1, 1'b0, enc(11'h0F0), 11'h0F0});
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_single_sweep();
      test_double_sweep();
      test_reset_midstream();
      @(negedge clk);
      in_valid = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
